// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage registers: state encoding,
// default register-index width and the hard-wired zero register index.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam int RD_W_DEF = 5;
    localparam int X0_IDX   = 0;

    // The encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_TWO   = ST_TWO
    } state_t;

endpackage

// File: rtl/wb_pipe_stage.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// flush, and a write-enable guard that never lets x0 be written.
module wb_pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int PAYLOAD_W = 3*WIDTH+2,
    parameter int RD_W      = RD_W_DEF,
    parameter int SKID      = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [RD_W-1:0]      in_rd,
    input  logic                 in_regwrite,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [RD_W-1:0]      out_rd,
    output logic                 out_regwrite,
    output logic [1:0]           occupancy
);

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [RD_W-1:0]      rd;
        logic                 rw;
    } entry_t;

    state_t state, state_nxt;
    entry_t in_ent, head_q, head_d, skid_q;
    logic   in_fire, out_fire;
    logic   head_load, head_from_skid, skid_load;

    assign in_ent   = '{payload: in_payload, rd: in_rd, rw: in_regwrite};
    assign out_valid = (state != S_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // With a skid entry in_ready is a pure state decode, cutting the out_ready path.
    assign in_ready = (SKID != 0) ? (state != S_TWO)
                                  : ((state == S_EMPTY) | out_ready);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt      = state;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_nxt = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_fire) begin
                        head_load = 1'b1;
                        state_nxt = S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_fire && (out_fire || SKID == 0)) begin
                        head_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_nxt = S_TWO;
                    end else if (out_fire) begin
                        state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (out_fire) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        state_nxt      = S_ONE;
                    end
                end
                default: state_nxt = S_EMPTY;
            endcase
        end
    end

    assign head_d = head_from_skid ? skid_q : in_ent;

    // NOTE: data registers are reset too, so out_payload is never X after reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)            head_q <= '0;
        else if (head_load) head_q <= head_d;
    end

    generate
        if (SKID != 0) begin : g_skid
            always_ff @(posedge CLK or posedge RST) begin
                if (RST)            skid_q <= '0;
                else if (skid_load) skid_q <= in_ent;
            end
        end else begin : g_noskid
            assign skid_q = '0;
        end
    endgenerate

    assign out_payload  = head_q.payload;
    assign out_rd       = head_q.rd;
    assign out_regwrite = out_valid & head_q.rw & (head_q.rd != RD_W'(X0_IDX));
    assign occupancy    = state;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Self-checking bench: a SKID=1 and a SKID=0 stage share one stimulus stream and
// are each compared every cycle against a queue-based model of the stage.
module tb_wb_pipe_stage;

    localparam int PW = 26;   // PAYLOAD_W for WIDTH=8
    localparam int RW = 5;

    logic          CLK, RST;
    logic          in_valid, in_regwrite, flush, out_ready;
    logic [PW-1:0] in_payload;
    logic [RW-1:0] in_rd;

    logic          in_ready_a, out_valid_a, out_regwrite_a;
    logic [PW-1:0] out_payload_a;
    logic [RW-1:0] out_rd_a;
    logic [1:0]    occupancy_a;
    logic          in_ready_b, out_valid_b, out_regwrite_b;
    logic [PW-1:0] out_payload_b;
    logic [RW-1:0] out_rd_b;
    logic [1:0]    occupancy_b;

    wb_pipe_stage #(.WIDTH(8), .SKID(1)) dut_a (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_payload(in_payload), .in_rd(in_rd), .in_regwrite(in_regwrite),
        .flush(flush), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_payload(out_payload_a), .out_rd(out_rd_a),
        .out_regwrite(out_regwrite_a), .occupancy(occupancy_a));

    wb_pipe_stage #(.WIDTH(8), .SKID(0)) dut_b (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_payload(in_payload), .in_rd(in_rd), .in_regwrite(in_regwrite),
        .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_payload(out_payload_b), .out_rd(out_rd_b),
        .out_regwrite(out_regwrite_b), .occupancy(occupancy_b));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [PW-1:0] pl;
        logic [RW-1:0] rd;
        bit            rw;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs follow from the model contents: the head is the oldest entry.
    task automatic model_cmp(input bit sk);
        int   n;
        ent_t h;
        bit   exp_ir;
        n = sk ? qa.size() : qb.size();
        h = '{pl: '0, rd: '0, rw: 1'b0};
        if (n > 0) h = sk ? qa[0] : qb[0];
        exp_ir = sk ? (n < 2) : (n == 0 || out_ready);
        if (sk) begin
            check("a_out_valid", 32'(out_valid_a), 32'(n > 0));
            check("a_occupancy", 32'(occupancy_a), 32'(n));
            check("a_in_ready", 32'(in_ready_a), 32'(exp_ir));
            check("a_out_regwrite", 32'(out_regwrite_a), 32'(n > 0 && h.rw && h.rd != 0));
            if (n > 0) begin
                check("a_out_payload", 32'(out_payload_a), 32'(h.pl));
                check("a_out_rd", 32'(out_rd_a), 32'(h.rd));
            end
        end else begin
            check("b_out_valid", 32'(out_valid_b), 32'(n > 0));
            check("b_occupancy", 32'(occupancy_b), 32'(n));
            check("b_in_ready", 32'(in_ready_b), 32'(exp_ir));
            check("b_out_regwrite", 32'(out_regwrite_b), 32'(n > 0 && h.rw && h.rd != 0));
            if (n > 0) begin
                check("b_out_payload", 32'(out_payload_b), 32'(h.pl));
                check("b_out_rd", 32'(out_rd_b), 32'(h.rd));
            end
        end
    endtask

    task automatic drive(input bit iv, input logic [PW-1:0] pl, input logic [RW-1:0] rd,
                         input bit rw, input bit fl, input bit ordy);
        in_valid    = iv;
        in_payload  = pl;
        in_rd       = rd;
        in_regwrite = rw;
        flush       = fl;
        out_ready   = ordy;
        #3;
        model_cmp(1'b1);
        model_cmp(1'b0);
    endtask

    // Advance the model by one edge using the current inputs, then clock the DUTs.
    task automatic tick();
        ent_t e;
        bit   ina, inb, oa, ob;
        e   = '{pl: in_payload, rd: in_rd, rw: in_regwrite};
        ina = in_valid && (qa.size() < 2);
        inb = in_valid && (qb.size() == 0 || out_ready);
        oa  = (qa.size() > 0) && out_ready;
        ob  = (qb.size() > 0) && out_ready;
        if (RST || flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (oa) void'(qa.pop_front());
            if (ina) qa.push_back(e);
            if (ob) void'(qb.pop_front());
            if (inb) qb.push_back(e);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_out_valid"}, 32'(out_valid_a), 0);
        check({tag, "_a_occupancy"}, 32'(occupancy_a), 0);
        check({tag, "_a_in_ready"}, 32'(in_ready_a), 1);
        check({tag, "_a_out_regwrite"}, 32'(out_regwrite_a), 0);
        check({tag, "_a_out_payload"}, 32'(out_payload_a), 0);
        check({tag, "_a_out_rd"}, 32'(out_rd_a), 0);
        check({tag, "_b_out_valid"}, 32'(out_valid_b), 0);
        check({tag, "_b_in_ready"}, 32'(in_ready_b), 1);
        check({tag, "_b_out_payload"}, 32'(out_payload_b), 0);
    endtask

    typedef struct {
        bit            iv;
        logic [PW-1:0] pl;
        logic [RW-1:0] rd;
        bit            rw, fl, ordy;
        logic [1:0]    e_occ;
        bit            e_ir, e_ov;
        logic [PW-1:0] e_head;
        logic [RW-1:0] e_rd;
        bit            e_orw;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Inputs | expected SKID=1 outputs observed before the edge of that cycle.
        vecs[0]  = '{1, 26'd1,  5'd5, 1, 0, 1, 2'd0, 1, 0, 26'd0, 5'd0, 0};
        vecs[1]  = '{1, 26'd2,  5'd0, 1, 0, 1, 2'd1, 1, 1, 26'd1, 5'd5, 1};
        vecs[2]  = '{1, 26'd3,  5'd7, 0, 0, 0, 2'd1, 1, 1, 26'd2, 5'd0, 0};
        vecs[3]  = '{1, 26'd4,  5'd3, 1, 0, 0, 2'd2, 0, 1, 26'd2, 5'd0, 0};
        vecs[4]  = '{1, 26'd5,  5'd3, 1, 0, 0, 2'd2, 0, 1, 26'd2, 5'd0, 0};
        vecs[5]  = '{1, 26'd6,  5'd9, 1, 0, 1, 2'd2, 0, 1, 26'd2, 5'd0, 0};
        vecs[6]  = '{0, 26'd7,  5'd0, 0, 0, 1, 2'd1, 1, 1, 26'd3, 5'd7, 0};
        vecs[7]  = '{1, 26'd8,  5'd4, 1, 0, 0, 2'd0, 1, 0, 26'd0, 5'd0, 0};
        vecs[8]  = '{1, 26'd9,  5'd4, 1, 0, 0, 2'd1, 1, 1, 26'd8, 5'd4, 1};
        vecs[9]  = '{1, 26'd10, 5'd4, 1, 1, 0, 2'd2, 0, 1, 26'd8, 5'd4, 1};
        vecs[10] = '{0, 26'd0,  5'd0, 0, 0, 1, 2'd0, 1, 0, 26'd0, 5'd0, 0};

        RST = 1'b1;
        in_valid = 0; in_payload = '0; in_rd = '0; in_regwrite = 0; flush = 0; out_ready = 0;
        @(posedge CLK);
        #1;
        check_reset_outputs("por");
        RST = 1'b0;

        // Directed table: streaming, back-pressure, x0 guard, flush at occupancy 2.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].iv, vecs[i].pl, vecs[i].rd, vecs[i].rw, vecs[i].fl, vecs[i].ordy);
            check($sformatf("tbl%0d_occ", i), 32'(occupancy_a), 32'(vecs[i].e_occ));
            check($sformatf("tbl%0d_in_ready", i), 32'(in_ready_a), 32'(vecs[i].e_ir));
            check($sformatf("tbl%0d_out_valid", i), 32'(out_valid_a), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov) begin
                check($sformatf("tbl%0d_head", i), 32'(out_payload_a), 32'(vecs[i].e_head));
                check($sformatf("tbl%0d_rd", i), 32'(out_rd_a), 32'(vecs[i].e_rd));
                check($sformatf("tbl%0d_regwrite", i), 32'(out_regwrite_a), 32'(vecs[i].e_orw));
            end
            tick();
        end

        // Eight back-to-back payloads: one per cycle after one cycle of latency, both modes.
        for (int k = 0; k < 9; k++) begin
            drive(k < 8, PW'(k + 1), 5'd1, 1, 0, 1);
            if (k >= 1) begin
                check("stream_a", 32'(out_payload_a), 32'(k));
                check("stream_b", 32'(out_payload_b), 32'(k));
                check("stream_b_in_ready", 32'(in_ready_b), 1);
            end
            tick();
        end

        // SKID=0: in_ready follows out_ready combinationally while an entry is held.
        drive(1, 26'h11, 5'd2, 1, 0, 0);
        tick();
        drive(1, 26'h12, 5'd2, 1, 0, 0);
        check("skid0_stall_in_ready", 32'(in_ready_b), 0);
        out_ready = 1'b1;
        #1;
        check("skid0_release_in_ready", 32'(in_ready_b), 1);
        tick();

        // Asynchronous reset with the skid stage full, observed before any edge.
        drive(1, 26'h21, 5'd3, 1, 0, 0);
        tick();
        drive(1, 26'h22, 5'd3, 1, 0, 0);
        tick();
        check("pre_reset_occ", 32'(occupancy_a), 2);
        RST = 1'b1;
        #1;
        check_reset_outputs("async");
        tick();
        RST = 1'b0;
        drive(1, 26'h55, 5'd6, 1, 0, 0);
        tick();
        drive(0, 26'h0, 5'd0, 0, 0, 1);
        check("post_reset_accept", 32'(out_payload_a), 32'h55);
        tick();

        // Random traffic against the model; small rd range exercises the x0 guard often.
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 3) != 0), PW'($urandom), RW'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
